// File: rtl/cp0_regfile.sv
`default_nettype none
// ============================================================================
// Module      : cp0_regfile
// Description : MIPS-style CP0 registers (BadVAddr, Count, Compare, Status,
//               Cause, EPC) with exception entry/return and timer interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_regfile (
  input  logic        clk,
  input  logic        resetn,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic        exception_i,
  input  logic [4:0]  exception_type_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] current_pc_i,
  input  logic [31:0] bad_addr_i,
  input  logic        is_store_i,
  input  logic [5:0]  int_i,
  output logic [31:0] epc_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic        int_pending_o,
  output logic        timer_int_o
);

  localparam logic [4:0] c_REG_BADVADDR = 5'd8;
  localparam logic [4:0] c_REG_COUNT    = 5'd9;
  localparam logic [4:0] c_REG_COMPARE  = 5'd11;
  localparam logic [4:0] c_REG_STATUS   = 5'd12;
  localparam logic [4:0] c_REG_CAUSE    = 5'd13;
  localparam logic [4:0] c_REG_EPC      = 5'd14;

  localparam logic [4:0] c_EXC_INT      = 5'b00000;
  localparam logic [4:0] c_EXC_ADDR     = 5'b00001;
  localparam logic [4:0] c_EXC_OV       = 5'b00010;
  localparam logic [4:0] c_EXC_SYSCALL  = 5'b00011;
  localparam logic [4:0] c_EXC_BREAK    = 5'b00100;
  localparam logic [4:0] c_EXC_ERET     = 5'b00101;
  localparam logic [4:0] c_EXC_RI       = 5'b10101;
  localparam logic [4:0] c_EXC_BTS      = 5'b10111;
  localparam logic [4:0] c_EXC_NONE     = 5'b11111;

  localparam logic [4:0] c_CODE_INT     = 5'h00;
  localparam logic [4:0] c_CODE_ADEL    = 5'h04;
  localparam logic [4:0] c_CODE_ADES    = 5'h05;
  localparam logic [4:0] c_CODE_SYS     = 5'h08;
  localparam logic [4:0] c_CODE_BP      = 5'h09;
  localparam logic [4:0] c_CODE_RI      = 5'h0A;
  localparam logic [4:0] c_CODE_OV      = 5'h0C;

  // Status fields
  logic [7:0]  r_status_im;
  logic        r_status_exl;
  logic        r_status_ie;
  // Cause fields
  logic        r_cause_bd;
  logic        r_cause_ti;
  logic [5:0]  r_cause_ip_hw;
  logic [1:0]  r_cause_ip_sw;
  logic [4:0]  r_cause_exc;
  // Plain registers
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_tick;

  logic        w_wr;
  logic        w_exc_entry;
  logic        w_eret;
  logic        w_timer_match;
  logic [4:0]  w_exccode;
  logic [31:0] w_epc_entry;

  // An exception in the same cycle squashes the MTC0 completely.
  assign w_wr          = we_i & ~exception_i;
  assign w_eret        = exception_i & (exception_type_i == c_EXC_ERET);
  assign w_exc_entry   = exception_i
                       & (exception_type_i != c_EXC_ERET)
                       & (exception_type_i != c_EXC_BTS)
                       & (exception_type_i != c_EXC_NONE);
  assign w_timer_match = (r_count == r_compare) & (r_compare != 32'd0);
  assign w_epc_entry   = is_in_delayslot_i ? (current_pc_i - 32'd4) : current_pc_i;

  always_comb begin
    w_exccode = c_CODE_RI;
    case (exception_type_i)
      c_EXC_INT:     w_exccode = c_CODE_INT;
      c_EXC_ADDR:    w_exccode = is_store_i ? c_CODE_ADES : c_CODE_ADEL;
      c_EXC_OV:      w_exccode = c_CODE_OV;
      c_EXC_SYSCALL: w_exccode = c_CODE_SYS;
      c_EXC_BREAK:   w_exccode = c_CODE_BP;
      c_EXC_RI:      w_exccode = c_CODE_RI;
      default:       w_exccode = c_CODE_RI;
    endcase
  end

  // Count advances on every other clock; an MTC0 load leaves the phase alone.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tick  <= 1'b0;
      r_count <= 32'd0;
    end else begin
      r_tick <= ~r_tick;
      if (w_wr && (waddr_i == c_REG_COUNT))
        r_count <= wdata_i;
      else if (r_tick)
        r_count <= r_count + 32'd1;
    end
  end

  // TI is sticky; a Compare write clears it and wins over a coincident match.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_compare  <= 32'd0;
      r_cause_ti <= 1'b0;
    end else begin
      if (w_wr && (waddr_i == c_REG_COMPARE)) begin
        r_compare  <= wdata_i;
        r_cause_ti <= 1'b0;
      end else if (w_timer_match) begin
        r_cause_ti <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_status_im  <= 8'd0;
      r_status_exl <= 1'b0;
      r_status_ie  <= 1'b0;
    end else begin
      if (w_wr && (waddr_i == c_REG_STATUS)) begin
        r_status_im  <= wdata_i[15:8];
        r_status_exl <= wdata_i[1];
        r_status_ie  <= wdata_i[0];
      end else if (w_exc_entry) begin
        r_status_exl <= 1'b1;
      end else if (w_eret) begin
        r_status_exl <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cause_bd    <= 1'b0;
      r_cause_ip_hw <= 6'd0;
      r_cause_ip_sw <= 2'd0;
      r_cause_exc   <= 5'd0;
      r_epc         <= 32'd0;
      r_badvaddr    <= 32'd0;
    end else begin
      r_cause_ip_hw <= {int_i[5] | r_cause_ti, int_i[4:0]};
      if (w_wr && (waddr_i == c_REG_CAUSE))
        r_cause_ip_sw <= wdata_i[9:8];
      if (w_wr && (waddr_i == c_REG_EPC))
        r_epc <= wdata_i;
      if (w_exc_entry) begin
        r_cause_exc <= w_exccode;
        // Nested exceptions keep the original return point.
        if (!r_status_exl) begin
          r_epc      <= w_epc_entry;
          r_cause_bd <= is_in_delayslot_i;
        end
        if (exception_type_i == c_EXC_ADDR)
          r_badvaddr <= bad_addr_i;
      end
    end
  end

  assign status_o = {9'd0, 1'b1, 6'd0, r_status_im, 6'd0, r_status_exl, r_status_ie};
  assign cause_o  = {r_cause_bd, r_cause_ti, 14'd0, r_cause_ip_hw, r_cause_ip_sw,
                     1'b0, r_cause_exc, 2'b00};
  assign epc_o    = r_epc;

  assign timer_int_o   = r_cause_ti;
  assign int_pending_o = r_status_ie & ~r_status_exl
                       & (|({r_cause_ip_hw, r_cause_ip_sw} & r_status_im));

  always_comb begin
    rdata_o = 32'd0;
    case (raddr_i)
      c_REG_BADVADDR: rdata_o = r_badvaddr;
      c_REG_COUNT:    rdata_o = r_count;
      c_REG_COMPARE:  rdata_o = r_compare;
      c_REG_STATUS:   rdata_o = status_o;
      c_REG_CAUSE:    rdata_o = cause_o;
      c_REG_EPC:      rdata_o = r_epc;
      default:        rdata_o = 32'd0;
    endcase
  end

endmodule
`default_nettype wire
